// File: rtl/lsu_trigger_seq.sv
// LSU DC3 trigger comparator with per-channel hit thresholds and pairwise chaining.
// Fire bits are registered and presented to dec in DC4.
module lsu_trigger_seq #(
    parameter int unsigned NUM_TRIG = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned CNTW     = 8
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [NUM_TRIG-1:0]      trig_en,
    input  logic [NUM_TRIG-1:0]      trig_select,
    input  logic [NUM_TRIG-1:0]      trig_load,
    input  logic [NUM_TRIG-1:0]      trig_store,
    input  logic [NUM_TRIG-1:0]      trig_masken,
    input  logic [NUM_TRIG-1:0]      trig_chain,
    input  logic [NUM_TRIG*AW-1:0]   trig_tdata2,
    input  logic [NUM_TRIG*CNTW-1:0] trig_thresh,
    input  logic [NUM_TRIG-1:0]      cfg_wr,
    input  logic                     lsu_valid,
    input  logic                     lsu_dma,
    input  logic                     lsu_load,
    input  logic                     lsu_store,
    input  logic [1:0]               lsu_size,
    input  logic [AW-1:0]            lsu_addr,
    input  logic [AW-1:0]            store_data,
    input  logic                     flush,
    output logic [NUM_TRIG-1:0]      lsu_trigger_match_dc4,
    output logic [NUM_TRIG/2-1:0]    trig_armed,
    output logic [NUM_TRIG*CNTW-1:0] trig_hit_cnt
);

    localparam int unsigned NPAIR = NUM_TRIG / 2;

    logic [AW-1:0]       sdata_sized;
    logic [NUM_TRIG-1:0] cnt_hit;
    logic [NUM_TRIG-1:0] fire;
    logic [NUM_TRIG-1:0] match_q;

    always_comb begin
        case (lsu_size)
            2'd0:    sdata_sized = {{(AW-8){1'b0}}, store_data[7:0]};
            2'd1:    sdata_sized = {{(AW-16){1'b0}}, store_data[15:0]};
            default: sdata_sized = store_data;
        endcase
    end

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_ch
        logic [AW-1:0]   td;
        logic [AW-1:0]   opnd;
        logic [AW-1:0]   dc;
        logic            data_match;
        logic            raw_hit;
        logic [CNTW-1:0] thr;
        logic [CNTW:0]   cnt_inc;
        logic [CNTW-1:0] cnt_q, cnt_d;
        logic            hit;

        assign td   = trig_tdata2[i*AW +: AW];
        assign opnd = ~trig_select[i] ? lsu_addr : (trig_store[i] ? sdata_sized : '0);

        // NAPOT: bit 0 is always free, bit j is free while every lower tdata2 bit is one.
        always_comb begin
            logic run;
            run = trig_masken[i];
            for (int j = 0; j < int'(AW); j++) begin
                dc[j] = run;
                run   = run & td[j];
            end
        end

        assign data_match = &((opnd ~^ td) | dc);
        assign raw_hit = lsu_valid & ~lsu_dma & ~flush & trig_en[i] & data_match &
                         ((trig_store[i] & lsu_store) |
                          (trig_load[i] & lsu_load & ~trig_select[i]));

        assign thr     = (trig_thresh[i*CNTW +: CNTW] == '0) ? CNTW'(1)
                                                             : trig_thresh[i*CNTW +: CNTW];
        assign cnt_inc = {1'b0, cnt_q} + (CNTW+1)'(1);

        always_comb begin
            cnt_d = cnt_q;
            hit   = 1'b0;
            if (cfg_wr[i]) begin
                cnt_d = '0;
            end else if (raw_hit) begin
                if (cnt_inc >= {1'b0, thr}) begin
                    hit   = 1'b1;
                    cnt_d = '0;
                end else if (~&cnt_q) begin
                    cnt_d = cnt_inc[CNTW-1:0];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign cnt_hit[i]                   = hit;
        assign trig_hit_cnt[i*CNTW +: CNTW] = cnt_q;
    end

    for (genvar k = 0; k < NPAIR; k++) begin : g_pair
        logic chain;
        logic armed_q, armed_d;
        logic fire_lo, fire_hi;

        assign chain = trig_chain[2*k];

        // Same-cycle hits on both channels arm only; the odd channel needs an earlier arm.
        always_comb begin
            armed_d = armed_q;
            fire_lo = cnt_hit[2*k] & ~chain;
            fire_hi = cnt_hit[2*k+1] & ~chain;
            if (chain) begin
                if (cnt_hit[2*k]) begin
                    armed_d = 1'b1;
                end else if (cnt_hit[2*k+1] && armed_q) begin
                    fire_lo = 1'b1;
                    fire_hi = 1'b1;
                    armed_d = 1'b0;
                end
            end
            if (flush || cfg_wr[2*k] || cfg_wr[2*k+1]) armed_d = 1'b0;
        end

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) armed_q <= 1'b0;
            else        armed_q <= armed_d;
        end

        assign fire[2*k]     = fire_lo;
        assign fire[2*k+1]   = fire_hi;
        assign trig_armed[k] = armed_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) match_q <= '0;
        else        match_q <= fire;
    end

    assign lsu_trigger_match_dc4 = match_q;

    logic unused_chain_odd;
    assign unused_chain_odd = ^(trig_chain & {NPAIR{2'b10}});

endmodule
